// File: rtl/formula_n_pipe_aware_fsm.sv
// Issue/accumulate controller that sums isqrt of N_ARGS operands through one shared,
// externally instantiated pipelined isqrt. It flushes stale isqrt results after reset.
module formula_n_pipe_aware_fsm #(
    parameter int N_ARGS    = 3,
    parameter int ARG_W     = 32,
    parameter int ISQRT_LAT = 4,
    parameter int RES_W     = ARG_W/2 + $clog2(N_ARGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     arg_vld,
    output logic                     arg_rdy,
    input  logic [N_ARGS*ARG_W-1:0]  args,
    output logic                     res_vld,
    output logic [RES_W-1:0]         res,
    output logic                     isqrt_x_vld,
    output logic [ARG_W-1:0]         isqrt_x,
    input  logic                     isqrt_y_vld,
    input  logic [ARG_W/2-1:0]       isqrt_y
);

    localparam int Y_W     = ARG_W / 2;
    localparam int CNT_MAX = (ISQRT_LAT > N_ARGS) ? ISQRT_LAT : N_ARGS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(ISQRT_LAT);
    localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(N_ARGS - 1);
    localparam logic [CNT_W-1:0] ALL_RET    = CNT_W'(N_ARGS);

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ret_cnt;
    logic [ARG_W-1:0] arg_q [N_ARGS];
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_sum;
    logic             accept;
    logic             take_y;
    logic             done;

    function automatic logic [RES_W-1:0] zext_y(input logic [Y_W-1:0] y);
        return RES_W'(y);
    endfunction

    // Returns are only counted while an operation is in flight, and never past N_ARGS.
    assign accept  = (state == IDLE) && arg_vld;
    assign take_y  = isqrt_y_vld && ((state == ISSUE) || (state == DRAIN)) && (ret_cnt != ALL_RET);
    assign acc_sum = acc + (take_y ? zext_y(isqrt_y) : '0);
    assign done    = (state == DRAIN) && ((ret_cnt + CNT_W'(take_y)) == ALL_RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        arg_rdy     = 1'b0;
        isqrt_x_vld = 1'b0;
        isqrt_x     = '0;
        case (state)
            FLUSH: begin
                if (cnt == LAST_FLUSH) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                isqrt_x_vld = 1'b1;
                for (int k = 0; k < N_ARGS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        isqrt_x = arg_q[k];
                    end
                end
                if (cnt == LAST_ISSUE) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = FLUSH;
        endcase
    end

    // cnt times the flush window and then serves as the issue index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ret_cnt <= '0;
            acc     <= '0;
            res     <= '0;
            res_vld <= 1'b0;
        end else begin
            res_vld <= 1'b0;
            if (accept) begin
                cnt     <= '0;
                ret_cnt <= '0;
                acc     <= '0;
            end else begin
                if ((state == FLUSH) || (state == ISSUE)) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (take_y) begin
                    acc     <= acc_sum;
                    ret_cnt <= ret_cnt + CNT_W'(1);
                end
            end
            if (done) begin
                res     <= acc_sum;
                res_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_ARGS; k++) begin
                arg_q[k] <= args[k*ARG_W +: ARG_W];
            end
        end
    end

endmodule

// File: tb/tb_formula_n_pipe_aware_fsm.sv
// Bench for formula_n_pipe_aware_fsm: two configurations, each with a behavioural isqrt pipe,
// a cycle-timeline reference model, and directed operand sets with literal results.
module tb_formula_n_pipe_aware_fsm;

    logic clk;
    logic rst_n;

    logic         vld0, rdy0, rv0, xv0, yv0;
    logic [95:0]  args0;
    logic [17:0]  res0;
    logic [31:0]  x0;
    logic [15:0]  y0;

    logic         vld1, rdy1, rv1, xv1, yv1;
    logic [159:0] args1;
    logic [18:0]  res1;
    logic [31:0]  x1;
    logic [15:0]  y1;

    logic [1:0]   inj_v;
    logic [15:0]  inj_y;

    int checks = 0;
    int errors = 0;

    formula_n_pipe_aware_fsm #(.N_ARGS(3), .ARG_W(32), .ISQRT_LAT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .arg_vld(vld0), .arg_rdy(rdy0), .args(args0),
        .res_vld(rv0), .res(res0), .isqrt_x_vld(xv0), .isqrt_x(x0),
        .isqrt_y_vld(yv0), .isqrt_y(y0)
    );

    formula_n_pipe_aware_fsm #(.N_ARGS(5), .ARG_W(32), .ISQRT_LAT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .arg_vld(vld1), .arg_rdy(rdy1), .args(args1),
        .res_vld(rv1), .res(res1), .isqrt_x_vld(xv1), .isqrt_x(x1),
        .isqrt_y_vld(yv1), .isqrt_y(y1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] isqrt_f(input logic [31:0] v);
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(v)) r = t;
        end
        return r[15:0];
    endfunction

    // Behavioural isqrt pipes (not reset, so in-flight results survive a reset).
    bit        pv0 [4];
    bit [15:0] py0 [4];
    bit        pv1 [2];
    bit [15:0] py1 [2];

    always @(posedge clk) begin
        for (int k = 3; k > 0; k--) begin
            pv0[k] <= pv0[k-1];
            py0[k] <= py0[k-1];
        end
        pv0[0] <= xv0;
        py0[0] <= isqrt_f(x0);
        pv1[1] <= pv1[0];
        py1[1] <= py1[0];
        pv1[0] <= xv1;
        py1[0] <= isqrt_f(x1);
    end

    assign yv0 = pv0[3] | inj_v[0];
    assign y0  = inj_v[0] ? inj_y : py0[3];
    assign yv1 = pv1[1] | inj_v[1];
    assign y1  = inj_v[1] ? inj_y : py1[1];

    logic        avld [2];
    logic [31:0] iarg [2][5];
    logic        dut_rdy [2];
    logic        dut_rv [2];
    logic        dut_xv [2];
    logic [31:0] dut_x [2];
    logic [31:0] dut_res [2];

    assign avld[0] = vld0;
    assign avld[1] = vld1;
    assign dut_rdy[0] = rdy0;
    assign dut_rdy[1] = rdy1;
    assign dut_rv[0]  = rv0;
    assign dut_rv[1]  = rv1;
    assign dut_xv[0]  = xv0;
    assign dut_xv[1]  = xv1;
    assign dut_x[0]   = x0;
    assign dut_x[1]   = x1;
    assign dut_res[0] = 32'(res0);
    assign dut_res[1] = 32'(res1);

    always_comb begin
        for (int k = 0; k < 3; k++) iarg[0][k] = args0[k*32 +: 32];
        iarg[0][3] = 32'd0;
        iarg[0][4] = 32'd0;
        for (int k = 0; k < 5; k++) iarg[1][k] = args1[k*32 +: 32];
    end

    // Reference model: a per-instance timeline counted from reset release and from acceptance.
    function automatic int na(input int i);
        return (i == 0) ? 3 : 5;
    endfunction

    function automatic int lt(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    int          rel_e [2];
    int          bt [2];
    longint      msum [2];
    longint      mres [2];
    logic [31:0] marg [2][5];
    bit          m_take;

    function automatic bit e_rdy(input int i);
        return (rel_e[i] > lt(i)) && ((bt[i] == 0) || (bt[i] == na(i) + lt(i) + 1));
    endfunction

    function automatic bit e_xv(input int i);
        return (bt[i] >= 1) && (bt[i] <= na(i));
    endfunction

    function automatic longint e_x(input int i);
        if (e_xv(i)) return longint'(marg[i][bt[i]-1]);
        return 0;
    endfunction

    function automatic bit e_rv(input int i);
        return bt[i] == na(i) + lt(i) + 1;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            rel_e[i] = 0;
            bt[i]    = 0;
            msum[i]  = 0;
            mres[i]  = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    rel_e[i] = 0;
                    bt[i]    = 0;
                    mres[i]  = 0;
                end else begin
                    m_take = avld[i] && e_rdy(i);
                    if (rel_e[i] < 1000) rel_e[i]++;
                    if (m_take) begin
                        bt[i]   = 1;
                        msum[i] = 0;
                        for (int k = 0; k < na(i); k++) begin
                            marg[i][k] = iarg[i][k];
                            msum[i] += longint'(isqrt_f(iarg[i][k]));
                        end
                    end else if (bt[i] != 0) begin
                        bt[i]++;
                        if (bt[i] > na(i) + lt(i) + 1) bt[i] = 0;
                    end
                    if (bt[i] == na(i) + lt(i) + 1) mres[i] = msum[i];
                end
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("arg_rdy%0d", i), longint'(dut_rdy[i]), longint'(e_rdy(i)));
                chk($sformatf("res_vld%0d", i), longint'(dut_rv[i]), longint'(e_rv(i)));
                chk($sformatf("x_vld%0d", i), longint'(dut_xv[i]), longint'(e_xv(i)));
                chk($sformatf("x%0d", i), longint'(dut_x[i]), e_x(i));
                chk($sformatf("res%0d", i), longint'(dut_res[i]), mres[i]);
            end
        end
    end

    logic [31:0] va [5];

    task automatic vec(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                       input logic [31:0] a3, input logic [31:0] a4);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3; va[4] = a4;
    endtask

    task automatic set_args(input int i);
        if (i == 0) args0 = {va[2], va[1], va[0]};
        else        args1 = {va[4], va[3], va[2], va[1], va[0]};
    endtask

    task automatic set_vld(input int i, input logic v);
        if (i == 0) vld0 = v;
        else        vld1 = v;
    endtask

    task automatic wait_rdy(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!dut_rdy[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_rdy%0d", i), longint'(dut_rdy[i]), 1);
    endtask

    task automatic run_one(input int i, input longint exp_res, input int exp_nx);
        int n;
        int nx;
        bit got;
        wait_rdy(i);
        set_args(i);
        set_vld(i, 1'b1);
        n = 0;
        nx = 0;
        got = 0;
        while (n < 50 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) set_vld(i, 1'b0);
            if (dut_xv[i]) nx++;
            if (dut_rv[i]) got = 1;
        end
        chk($sformatf("latency%0d", i), n, 8);
        chk($sformatf("result%0d", i), longint'(dut_res[i]), exp_res);
        chk($sformatf("issue_cycles%0d", i), nx, exp_nx);
    endtask

    int cnt_low;
    int nlow;

    initial begin
        rst_n = 1'b1;
        vld0 = 1'b0;
        vld1 = 1'b0;
        args0 = '0;
        args1 = '0;
        inj_v = 2'b00;
        inj_y = 16'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rdy", longint'(rdy0), 0);
        chk("reset_res_vld", longint'(rv0), 0);
        chk("reset_x_vld", longint'(xv0), 0);
        chk("reset_res", longint'(res0), 0);
        chk("reset_res1", longint'(res1), 0);

        // Flush window: arg_vld and spurious returns must be ignored.
        #2 rst_n = 1'b1;
        cnt_low = rdy0 ? 0 : 1;
        vec(5, 5, 5, 0, 0);
        set_args(0);
        vld0 = 1'b1;
        for (int m = 1; m <= 10; m++) begin
            @(negedge clk);
            if (m == 2) begin
                inj_v = 2'b11;
                inj_y = 16'd7;
            end
            if (m == 3) begin
                inj_v = 2'b00;
                vld0  = 1'b0;
            end
            if (rdy0) break;
            cnt_low++;
        end
        chk("flush_cycles", cnt_low, 5);
        inj_v = 2'b11;
        @(negedge clk);
        inj_v = 2'b00;

        vec(1, 1, 1, 0, 0);
        run_one(0, 3, 3);
        vec(1, 4, 9, 0, 0);
        run_one(0, 6, 3);
        vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_one(0, 196605, 3);

        // Back-to-back with arg_vld held high.
        vec(16, 25, 36, 0, 0);
        wait_rdy(0);
        set_args(0);
        vld0 = 1'b1;
        nlow = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n == 1) begin
                vec(0, 0, 0, 0, 0);
                set_args(0);
            end
            if (n <= 7 && !rdy0) nlow++;
            if (n == 8) begin
                chk("b2b_vld1", longint'(rv0), 1);
                chk("b2b_res1", longint'(res0), 15);
                chk("b2b_rdy8", longint'(rdy0), 1);
            end
            if (n == 9) vld0 = 1'b0;
            if (n == 16) begin
                chk("b2b_vld2", longint'(rv0), 1);
                chk("b2b_res2", longint'(res0), 0);
            end
        end
        chk("b2b_rdy_low", nlow, 7);

        vec(100, 81, 64, 49, 36);
        run_one(1, 40, 5);

        // Reset while returns of {4,4,4} are still in flight.
        vec(4, 4, 4, 0, 0);
        wait_rdy(0);
        set_args(0);
        vld0 = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) vld0 = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdy", longint'(rdy0), 0);
        chk("midrst_res_vld", longint'(rv0), 0);
        chk("midrst_x_vld", longint'(xv0), 0);
        chk("midrst_res", longint'(res0), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        vec(9, 9, 9, 0, 0);
        run_one(0, 9, 3);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
